// File: rtl/alu_pkg.sv
// alu_pkg: opcode and state enums plus op classification shared by the sequential ALU
package alu_pkg;
    typedef enum logic [3:0] {
        OP_PASS, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NEG,
        OP_SHL, OP_SHR, OP_ASR, OP_SWAPH, OP_SWAPN, OP_MUL, OP_DIV, OP_RSVD
    } op_e;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
    function automatic logic is_multicycle(op_e o);
        return o == OP_MUL || o == OP_DIV;
    endfunction
endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative shift-add multiplier / restoring divider, one bit per cycle
module alu_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_div,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             dz
);
    localparam int CW = $clog2(WIDTH);
    logic             busy, div_q, dz_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi_q, lo_q, m_q, diff;
    logic [WIDTH:0]   sum, r_sh;
    logic             ge;
    // lo/hi are the post-step values so the owner can capture them on the final step edge
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        r_sh = {hi_q, lo_q[WIDTH-1]};
        ge   = r_sh >= {1'b0, m_q};
        diff = r_sh[WIDTH-1:0] - m_q;
        hi   = div_q ? (ge ? diff : r_sh[WIDTH-1:0]) : sum[WIDTH:1];
        lo   = div_q ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
    end
    assign done = busy && cnt == CW'(WIDTH - 1);
    assign dz   = dz_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            div_q <= 1'b0;
            dz_q  <= 1'b0;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            div_q <= is_div;
            dz_q  <= b == '0;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= a;
            m_q   <= b;
        end else if (busy) begin
            hi_q <= hi;
            lo_q <= lo;
            cnt  <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with registered flags and valid/ready handshakes on both sides
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic             ci,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             dz
);
    state_e           state;
    op_e              op_q;
    logic             ci_q, r_c, md_done, md_dz;
    logic [WIDTH-1:0] a_q, b_q, r_y, r_hi, md_lo, md_hi;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk(clk), .rst(rst),
        .start(in_valid && in_ready && is_multicycle(op_e'(op))),
        .a(a), .b(b), .is_div(op_e'(op) == OP_DIV),
        .done(md_done), .lo(md_lo), .hi(md_hi), .dz(md_dz)
    );
    always_comb begin
        r_y = '0;
        r_c = 1'b0;
        case (op_q)
            OP_PASS:  r_y = b_q;
            OP_ADD:   {r_c, r_y} = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, ci_q};
            OP_SUB:   {r_c, r_y} = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, ci_q};
            OP_AND:   r_y = a_q & b_q;
            OP_OR:    r_y = a_q | b_q;
            OP_XOR:   r_y = a_q ^ b_q;
            OP_NOT:   r_y = ~a_q;
            OP_NEG:   r_y = -a_q;
            OP_SHL:   {r_c, r_y} = {a_q, ci_q};
            OP_SHR:   {r_y, r_c} = {ci_q, a_q};
            OP_ASR:   {r_y, r_c} = {a_q[WIDTH-1], a_q};
            OP_SWAPH: r_y = {a_q[WIDTH/2-1:0], a_q[WIDTH-1:WIDTH/2]};
            OP_SWAPN: for (int i = 0; i < WIDTH / 8; i++) r_y[8*i+:8] = {a_q[8*i+:4], a_q[8*i+4+:4]};
            OP_MUL:   {r_c, r_y} = {|md_hi, md_lo};
            OP_DIV:   r_y = md_lo;
            default:  r_y = '0;
        endcase
        r_hi = is_multicycle(op_q) ? md_hi : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= OP_PASS;
            ci_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            y     <= '0;
            y_hi  <= '0;
            zero  <= 1'b0;
            neg   <= 1'b0;
            carry <= 1'b0;
            dz    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state <= EXEC;
                    op_q  <= op_e'(op);
                    ci_q  <= ci;
                    a_q   <= a;
                    b_q   <= b;
                end
                EXEC: if (!is_multicycle(op_q) || md_done) begin
                    state <= DONE;
                    y     <= r_y;
                    y_hi  <= r_hi;
                    zero  <= r_y == '0;
                    neg   <= r_y[WIDTH-1];
                    carry <= r_c;
                    dz    <= op_q == OP_DIV && md_dz;
                end
                default: if (out_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq covering directed cases, backpressure, reset abort and random ops
module tb_alu_seq;
    typedef struct packed {
        logic [15:0] y;
        logic [15:0] hi;
        logic        z, n, c, d;
        logic [7:0]  lat;
    } exp_t;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0, ci = 0;
    logic        in_ready, out_valid, zero, neg, carry, dz;
    logic [3:0]  op = 0;
    logic [15:0] a = 0, b = 0, y, y_hi;
    int          checks = 0, failures = 0;
    exp_t        q[$];
    alu_seq #(.WIDTH(16), .OPW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .ci(ci),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_hi(y_hi),
        .zero(zero), .neg(neg), .carry(carry), .dz(dz)
    );
    always #5 clk = ~clk;
    function automatic exp_t mk(logic [15:0] ey, logic [15:0] eh, logic ez, logic en, logic ec, logic ed, logic [7:0] el);
        exp_t e;
        e = {ey, eh, ez, en, ec, ed, el};
        return e;
    endfunction
    function automatic exp_t model(logic [3:0] o, logic [15:0] x, logic [15:0] v, logic cin);
        exp_t e;
        logic [16:0] s;
        logic [31:0] p;
        e = '0;
        e.lat = 2;
        case (o)
            0: e.y = v;
            1: begin s = {1'b0, x} + {1'b0, v} + {16'd0, cin}; e.y = s[15:0]; e.c = s[16]; end
            2: begin e.y = x - v - {15'd0, cin}; e.c = {1'b0, x} < {1'b0, v} + {16'd0, cin}; end
            3: e.y = x & v;
            4: e.y = x | v;
            5: e.y = x ^ v;
            6: e.y = ~x;
            7: e.y = 16'd0 - x;
            8: begin e.y = {x[14:0], cin}; e.c = x[15]; end
            9: begin e.y = {cin, x[15:1]}; e.c = x[0]; end
            10: begin e.y = {x[15], x[15:1]}; e.c = x[0]; end
            11: e.y = {x[7:0], x[15:8]};
            12: e.y = {x[11:8], x[15:12], x[3:0], x[7:4]};
            13: begin p = {16'd0, x} * {16'd0, v}; e.y = p[15:0]; e.hi = p[31:16]; e.c = p[31:16] != 0; e.lat = 17; end
            14: begin
                e.lat = 17;
                if (v == 0) begin e.y = 16'hFFFF; e.hi = x; e.d = 1; end
                else begin e.y = x / v; e.hi = x % v; end
            end
            default: e.y = 0;
        endcase
        e.z = e.y == 0;
        e.n = e.y[15];
        return e;
    endfunction
    task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] v, input logic cin, input exp_t e);
        int n = 0;
        while (in_ready !== 1 && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (in_ready !== 1) begin failures++; $display("FAIL issue_ready in_ready=%b required 1", in_ready); end
        op = o; a = x; b = v; ci = cin; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; op = 4'($urandom); a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
        q.push_back(e);
    endtask
    task automatic collect(input string name, input int hold);
        int n = 0;
        logic busy_ok = 1;
        exp_t e;
        do begin
            @(posedge clk); #1;
            n++;
            if (in_ready !== 0) busy_ok = 0;
        end while (out_valid !== 1 && n < 100);
        checks++;
        if (out_valid !== 1) begin
            failures++;
            $display("FAIL %s_timeout out_valid=%b required 1", name, out_valid);
            void'(q.pop_front());
            return;
        end
        e = q.pop_front();
        checks++;
        if (busy_ok !== 1) begin failures++; $display("FAIL %s_in_ready in_ready went high while busy, required 0", name); end
        checks++;
        if (8'(n + 1) !== e.lat) begin failures++; $display("FAIL %s_latency got %0d required %0d", name, n + 1, e.lat); end
        checks++;
        if (y !== e.y || y_hi !== e.hi) begin failures++; $display("FAIL %s_result y=%h y_hi=%h required y=%h y_hi=%h", name, y, y_hi, e.y, e.hi); end
        checks++;
        if ({zero, neg, carry, dz} !== {e.z, e.n, e.c, e.d})
            begin failures++; $display("FAIL %s_flags zncd=%b required %b", name, {zero, neg, carry, dz}, {e.z, e.n, e.c, e.d}); end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1 || in_ready !== 0 || y !== e.y || y_hi !== e.hi || {zero, neg, carry, dz} !== {e.z, e.n, e.c, e.d})
                begin failures++; $display("FAIL %s_hold ov=%b ir=%b y=%h zncd=%b required ov=1 ir=0 y=%h zncd=%b", name, out_valid, in_ready, y, {zero, neg, carry, dz}, e.y, {e.z, e.n, e.c, e.d}); end
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        checks++;
        if (in_ready !== 1 || out_valid !== 0) begin failures++; $display("FAIL %s_release ir=%b ov=%b required ir=1 ov=0", name, in_ready, out_valid); end
    endtask
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        checks++;
        if (in_ready !== 1 || out_valid !== 0 || y !== 0 || y_hi !== 0 || {zero, neg, carry, dz} !== 4'b0)
            begin failures++; $display("FAIL reset ir=%b ov=%b y=%h y_hi=%h zncd=%b required ir=1 ov=0 all zero", in_ready, out_valid, y, y_hi, {zero, neg, carry, dz}); end
    endtask
    task automatic test_add_sub();
        issue(1, 16'hFFFF, 16'h0001, 0, mk(16'h0000, 0, 1, 0, 1, 0, 2)); collect("add_wrap", 0);
        issue(2, 16'h0003, 16'h0005, 0, mk(16'hFFFE, 0, 0, 1, 1, 0, 2)); collect("sub_borrow", 0);
        issue(10, 16'h8001, 16'h0000, 0, mk(16'hC000, 0, 0, 1, 1, 0, 2)); collect("asr", 0);
        issue(15, 16'h1234, 16'h5678, 1, mk(16'h0000, 0, 1, 0, 0, 0, 2)); collect("reserved", 0);
    endtask
    task automatic test_muldiv();
        issue(13, 16'h1234, 16'h0100, 0, mk(16'h3400, 16'h0012, 0, 0, 1, 0, 17)); collect("mul", 0);
        issue(14, 16'd100, 16'd7, 0, mk(16'd14, 16'd2, 0, 0, 0, 0, 17)); collect("div", 0);
        issue(14, 16'h00AB, 16'h0000, 0, mk(16'hFFFF, 16'h00AB, 0, 1, 0, 1, 17)); collect("div_zero", 0);
        issue(13, 16'hFFFF, 16'hFFFF, 0, mk(16'h0001, 16'hFFFE, 0, 0, 1, 0, 17)); collect("mul_max", 0);
    endtask
    task automatic test_backpressure();
        issue(1, 16'h1234, 16'h0F0F, 1, mk(16'h2144, 0, 0, 0, 0, 0, 2)); collect("backpressure", 5);
        issue(11, 16'hA5C3, 16'h0, 0, mk(16'hC3A5, 0, 0, 1, 0, 0, 2)); collect("after_bp", 0);
    endtask
    task automatic test_rst_mid();
        issue(13, 16'h1234, 16'h5678, 0, model(13, 16'h1234, 16'h5678, 0));
        repeat (4) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        q.delete();
        checks++;
        if (in_ready !== 1 || out_valid !== 0 || y !== 0 || y_hi !== 0 || {zero, neg, carry, dz} !== 4'b0)
            begin failures++; $display("FAIL rst_mid ir=%b ov=%b y=%h y_hi=%h zncd=%b required ir=1 ov=0 all zero", in_ready, out_valid, y, y_hi, {zero, neg, carry, dz}); end
        issue(1, 16'h1111, 16'h2222, 1, mk(16'h3334, 0, 0, 0, 0, 0, 2)); collect("add_after_rst", 0);
        issue(14, 16'hFFFF, 16'h0010, 0, mk(16'h0FFF, 16'h000F, 0, 0, 0, 0, 17)); collect("div_after_rst", 0);
    endtask
    task automatic test_back_to_back();
        logic [3:0]  o;
        logic [15:0] x, v;
        logic        cin;
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(0, 15));
            x = 16'($urandom);
            v = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            cin = 1'($urandom);
            issue(o, x, v, cin, model(o, x, v, cin));
            collect("random", i % 3);
        end
    endtask
    initial begin
        test_reset();
        test_add_sub();
        test_muldiv();
        test_backpressure();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
